alu_div_sequencer: RTL

//  Iterative integer divider (DIV/DIVU/REM/REMU semantics) that owns no subtractor.
//  It sequences the shared execute-stage ALU through negate and restoring-divide steps.
//  It sits beside the ALU in the computational stage and drives the ALU op/operand muxes while busy.
//  The hazard unit stalls the pipeline while ReqReady is low.

---
 rtl/HighLevelControl.sv | 19 +
 rtl/alu_div_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/HighLevelControl.sv
// Shared execute-stage control types: the ALU operation encoding used by the
// pipeline and by units that borrow the ALU.
`timescale 1ns/1ps
package HighLevelControl;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      SLL  = 4'd5,
      SRL  = 4'd6,
      SRA  = 4'd7,
      SLT  = 4'd8,
      SLTU = 4'd9
   } aluOperation;

endpackage

// File: rtl/alu_div_sequencer.sv
// Iterative DIV/DIVU/REM/REMU sequencer that borrows the shared ALU subtractor.
// XLEN is 32, or 64 with XLEN_64; DIV_ZERO_FASTPATH_EN short-circuits divide-by-zero.
`timescale 1ns/1ps
`ifndef XLEN
`ifdef XLEN_64
`define XLEN 64
`else
`define XLEN 32
`endif
`endif

module alu_div_sequencer (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ReqValid,
   output logic                           ReqReady,
   input  logic                           ReqSigned,
   input  logic [`XLEN-1:0]               Dividend,
   input  logic [`XLEN-1:0]               Divisor,
   output logic                           ResValid,
   input  logic                           ResReady,
   output logic [`XLEN-1:0]               Quotient,
   output logic [`XLEN-1:0]               Remainder,
   output logic                           DivByZero,
   output HighLevelControl::aluOperation  AluOperation,
   output logic [`XLEN-1:0]               AluOperandA,
   output logic [`XLEN-1:0]               AluOperandB,
   input  logic [`XLEN-1:0]               AluResult,
   input  logic                           AluCarry
);

   localparam int XLEN = `XLEN;
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, DIVIDE, FIX_Q, FIX_R, DONE} state_t;

   state_t          state_reg;
   logic [XLEN-1:0] q_reg;
   logic [XLEN-1:0] r_reg;
   logic [XLEN-1:0] b_reg;
   logic [XLEN-1:0] dividend_reg;
   logic            neg_a_reg;
   logic            neg_b_reg;
   logic            zero_reg;
   logic [CW-1:0]   count_reg;

   // One restoring step: AluOperandA already carries the shifted remainder.
   logic [XLEN-1:0] rsh;
   logic            take;
   logic [XLEN-1:0] r_new;
   logic [XLEN-1:0] q_new;
   logic [XLEN-1:0] b_mag;

   assign rsh   = {r_reg[XLEN-2:0], q_reg[XLEN-1]};
   assign take  = r_reg[XLEN-1] | ~AluCarry;
   assign r_new = take ? AluResult : rsh;
   assign q_new = {q_reg[XLEN-2:0], take};
   assign b_mag = neg_b_reg ? AluResult : b_reg;

   assign AluOperation = HighLevelControl::SUB;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         ReqReady     <= 1'b1;
         ResValid     <= 1'b0;
         Quotient     <= '0;
         Remainder    <= '0;
         DivByZero    <= 1'b0;
         AluOperandA  <= '0;
         AluOperandB  <= '0;
         q_reg        <= '0;
         r_reg        <= '0;
         b_reg        <= '0;
         dividend_reg <= '0;
         neg_a_reg    <= 1'b0;
         neg_b_reg    <= 1'b0;
         zero_reg     <= 1'b0;
         count_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ReqValid) begin
                  ReqReady     <= 1'b0;
                  q_reg        <= Dividend;
                  b_reg        <= Divisor;
                  dividend_reg <= Dividend;
                  neg_a_reg    <= ReqSigned & Dividend[XLEN-1];
                  neg_b_reg    <= ReqSigned & Divisor[XLEN-1];
                  zero_reg     <= (Divisor == '0);
`ifdef DIV_ZERO_FASTPATH_EN
                  if (Divisor == '0) begin
                     state_reg <= DONE;
                     Quotient  <= '1;
                     Remainder <= Dividend;
                     DivByZero <= 1'b1;
                     ResValid  <= 1'b1;
                  end else begin
                     state_reg   <= NEG_A;
                     AluOperandA <= '0;
                     AluOperandB <= Dividend;
                  end
`else
                  state_reg   <= NEG_A;
                  AluOperandA <= '0;
                  AluOperandB <= Dividend;
`endif
               end
            end
            NEG_A: begin
               if (neg_a_reg)
                  q_reg <= AluResult;
               r_reg       <= '0;
               AluOperandB <= b_reg;
               state_reg   <= NEG_B;
            end
            NEG_B: begin
               b_reg       <= b_mag;
               AluOperandA <= {{(XLEN-1){1'b0}}, q_reg[XLEN-1]};
               AluOperandB <= b_mag;
               count_reg   <= LAST;
               state_reg   <= DIVIDE;
            end
            DIVIDE: begin
               r_reg <= r_new;
               q_reg <= q_new;
               if (count_reg == '0) begin
                  AluOperandA <= '0;
                  AluOperandB <= q_new;
                  state_reg   <= FIX_Q;
               end else begin
                  AluOperandA <= {r_new[XLEN-2:0], q_new[XLEN-1]};
                  count_reg   <= count_reg - 1'b1;
               end
            end
            FIX_Q: begin
               if (zero_reg)
                  Quotient <= '1;
               else if (neg_a_reg ^ neg_b_reg)
                  Quotient <= AluResult;
               else
                  Quotient <= q_reg;
               AluOperandB <= r_reg;
               state_reg   <= FIX_R;
            end
            FIX_R: begin
               if (zero_reg)
                  Remainder <= dividend_reg;
               else if (neg_a_reg)
                  Remainder <= AluResult;
               else
                  Remainder <= r_reg;
               DivByZero   <= zero_reg;
               ResValid    <= 1'b1;
               AluOperandB <= '0;
               state_reg   <= DONE;
            end
            DONE: begin
               if (ResReady) begin
                  ResValid  <= 1'b0;
                  ReqReady  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
